// File: rtl/hdmi_pll_pkg.sv
// Shared types and default timing for the HDMI PLL supervisor.
// Defaults assume the free-running 50 MHz reference clock.
// Width helpers keep the derived counter widths in one place.
package hdmi_pll_pkg;

  // Supervisor sequence states
  typedef enum logic [2:0] {
    RESET_PULSE = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE      = 3'd2,
    RUN         = 3'd3,
    FAULT       = 3'd4
  } pll_state_e;

  // Default timing at 50 MHz (20 ns per cycle)
  localparam int DEF_RESET_CYCLES  = 16;       // PLL reset pulse width
  localparam int DEF_LOCK_TIMEOUT  = 1000000;  // 20 ms per lock attempt
  localparam int DEF_STABLE_CYCLES = 5000;     // 100 us of continuous lock
  localparam int DEF_MAX_RETRIES   = 3;        // retries after the first failed attempt

  // Largest of three values, used to size the shared counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // $clog2 clamped to at least one bit so degenerate parameters still give a legal vector
  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: 1-bit two-flop synchroniser for asynchronous status inputs.
// Latency: 2 clk cycles from the first edge that samples a new level.
// Backpressure: none; level signal passes straight through.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; second flop gives it a full cycle to resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hdmi_pll_supervisor.sv
// Purpose: sequences HDMI PLL reset, qualifies lock, gates the HDMI domain reset.
// Latency: ready rises STABLE_CYCLES+2 clkin edges after lock is first sampled high.
// Backpressure: none; all interfaces are registered levels or single-cycle pulses.
module hdmi_pll_supervisor
  import hdmi_pll_pkg::*;
#(
  parameter  int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter  int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter  int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter  int MAX_RETRIES   = DEF_MAX_RETRIES,
  localparam int CNT_W         = clog2_min1(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)),
  localparam int RTY_W         = clog2_min1(MAX_RETRIES + 1)
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             lock,
  input  logic             restart,
  output logic             pll_reset,
  output logic             rst_out,
  output logic             ready,
  output logic             fault,
  output logic             lock_lost,
  output logic [RTY_W-1:0] retries
);

  // Terminal counts; compares are equality only and the counter is cleared on every state entry
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             pll_reset_q, pll_reset_d;
  logic             rst_out_q, rst_out_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             lock_lost_q, lock_lost_d;
  logic             lock_s;

  // PLL lock is asynchronous to clkin; the sequencer only ever looks at lock_s
  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (lock),
    .q   (lock_s)
  );

  // Next-state, counter and retry bookkeeping; restart overrides every other transition
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rty_d       = rty_q;
    lock_lost_d = 1'b0;

    if (restart) begin
      state_d = RESET_PULSE;
      cnt_d   = '0;
      rty_d   = '0;
    end else begin
      case (state_q)
        RESET_PULSE: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (rty_q == RTY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = RESET_PULSE;
              rty_d   = rty_q + RTY_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        STABLE: begin
          // A lock glitch restarts the full timeout but is not counted as a failed attempt
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        RUN: begin
          // Loss of lock in service begins a fresh episode with its own retry budget
          if (!lock_s) begin
            state_d     = RESET_PULSE;
            cnt_d       = '0;
            rty_d       = '0;
            lock_lost_d = 1'b1;
          end
        end

        FAULT: begin
          state_d = FAULT;
        end

        default: begin
          state_d = RESET_PULSE;
          cnt_d   = '0;
          rty_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they register in the same cycle as the transition
  always_comb begin
    pll_reset_d = (state_d == RESET_PULSE) || (state_d == FAULT);
    rst_out_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  // Sequencer state and registered outputs; reset puts the PLL back into reset immediately
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_PULSE;
      cnt_q       <= '0;
      rty_q       <= '0;
      pll_reset_q <= 1'b1;
      rst_out_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rty_q       <= rty_d;
      pll_reset_q <= pll_reset_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign lock_lost = lock_lost_q;
  assign retries   = rty_q;

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Directed bench for hdmi_pll_supervisor with short timing parameters.
// Edge numbers count clkin rising edges after reset release; outputs sampled 1 ns after each edge.
// Expected values are hand-derived edge numbers for the lock sequence.
module tb_hdmi_pll_supervisor;

  localparam int RC = 4;
  localparam int LT = 100;
  localparam int SC = 10;
  localparam int MR = 2;

  logic       clkin;
  logic       reset;
  logic       lock;
  logic       restart;
  logic       pll_reset;
  logic       rst_out;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retries;

  int n_checks;
  int n_errors;
  int ecnt;
  int inv_bad;
  int hold_bad;

  hdmi_pll_supervisor #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .lock      (lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .rst_out   (rst_out),
    .ready     (ready),
    .fault     (fault),
    .lock_lost (lock_lost),
    .retries   (retries)
  );

  initial clkin = 1'b0;
  always #10 clkin = ~clkin;

  // Invariants that must hold on every cycle: ready implies rst_out low, fault implies not ready
  always @(negedge clkin) begin
    if ((ready && rst_out) || (fault && ready)) inv_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Advance to absolute edge n (relative to last reset release), sampling 1 ns after it
  task automatic goto_edge(input int n);
    while (ecnt < n) begin
      @(posedge clkin);
      #1;
      ecnt++;
    end
  endtask

  // Assert reset across two edges and release it mid-cycle; the next edge is edge 1
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clkin);
    @(posedge clkin);
    #3;
    reset = 1'b0;
    ecnt  = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    inv_bad  = 0;
    hold_bad = 0;
    ecnt     = 0;
    reset    = 1'b1;
    lock     = 1'b0;
    restart  = 1'b0;

    // ---- Lock never rises: three attempts then sticky fault ----
    do_reset();
    check("rst_pll_reset", pll_reset, 1);
    check("rst_rst_out",   rst_out,   1);
    check("rst_ready",     ready,     0);
    check("rst_fault",     fault,     0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_retries",   retries,   0);
    goto_edge(3);   check("t1_pll_reset_e3",   pll_reset, 1);
    goto_edge(4);   check("t1_pll_reset_e4",   pll_reset, 0);
    goto_edge(103); check("t1_retries_e103",   retries,   0);
    goto_edge(104); check("t1_retries_e104",   retries,   1);
                    check("t1_pll_reset_e104", pll_reset, 1);
    goto_edge(107); check("t1_pll_reset_e107", pll_reset, 1);
    goto_edge(108); check("t1_pll_reset_e108", pll_reset, 0);
    goto_edge(208); check("t1_retries_e208",   retries,   2);
                    check("t1_pll_reset_e208", pll_reset, 1);
    goto_edge(212); check("t1_pll_reset_e212", pll_reset, 0);
    goto_edge(311); check("t1_fault_e311",     fault,     0);
    goto_edge(312); check("t1_fault_e312",     fault,     1);
                    check("t1_pll_reset_e312", pll_reset, 1);
                    check("t1_ready_e312",     ready,     0);
    for (int i = 0; i < 1000; i++) begin
      goto_edge(313 + i);
      if ({fault, pll_reset, ready, rst_out} !== 4'b1101) hold_bad++;
    end
    check("t1_fault_hold_bad_cycles", hold_bad, 0);

    // ---- Restart out of FAULT ----
    restart = 1'b1;
    goto_edge(1313);
    restart = 1'b0;
    check("t5_fault_cleared",  fault,     0);
    check("t5_retries",        retries,   0);
    check("t5_pll_reset_e0",   pll_reset, 1);
    check("t5_lock_lost",      lock_lost, 0);
    goto_edge(1316); check("t5_pll_reset_e3", pll_reset, 1);
    goto_edge(1317); check("t5_pll_reset_e4", pll_reset, 0);

    // ---- Lock rises and holds: L = 11, ready at edge 23 ----
    do_reset();
    goto_edge(10);
    lock = 1'b1;
    goto_edge(22);
    check("t2_ready_e22",   ready,   0);
    check("t2_rst_out_e22", rst_out, 1);
    goto_edge(23);
    check("t2_ready_e23",     ready,     1);
    check("t2_rst_out_e23",   rst_out,   0);
    check("t2_retries_e23",   retries,   0);
    check("t2_pll_reset_e23", pll_reset, 0);

    // ---- Restart coinciding with lock drop in RUN resolves as restart ----
    goto_edge(25);
    lock = 1'b0;
    goto_edge(27);
    check("t5r_ready_e27", ready, 1);
    restart = 1'b1;
    goto_edge(28);
    restart = 1'b0;
    check("t5r_lock_lost_e28", lock_lost, 0);
    check("t5r_ready_e28",     ready,     0);
    check("t5r_rst_out_e28",   rst_out,   1);
    check("t5r_pll_reset_e28", pll_reset, 1);
    check("t5r_retries_e28",   retries,   0);
    goto_edge(29); check("t5r_lock_lost_e29", lock_lost, 0);
    goto_edge(31); check("t5r_pll_reset_e31", pll_reset, 1);
    goto_edge(32); check("t5r_pll_reset_e32", pll_reset, 0);

    // ---- One timeout, then a 3-cycle glitch at STABLE count 5, then loss in RUN ----
    do_reset();
    goto_edge(104); check("t3_retries_e104", retries, 1);
    goto_edge(110);
    lock = 1'b1;     // L = 111, STABLE entered at edge 113
    goto_edge(116);
    lock = 1'b0;     // sampled low at 117..119
    goto_edge(119);
    lock = 1'b1;     // L' = 120, ready expected at 132
    check("t3_ready_e119",     ready,     0);
    check("t3_pll_reset_e119", pll_reset, 0);
    check("t3_retries_e119",   retries,   1);
    goto_edge(123); check("t3_ready_e123", ready, 0);
    goto_edge(131); check("t3_ready_e131", ready, 0);
    goto_edge(132);
    check("t3_ready_e132",   ready,   1);
    check("t3_rst_out_e132", rst_out, 0);
    check("t3_retries_e132", retries, 1);

    goto_edge(135);
    lock = 1'b0;     // drop first sampled at edge 136
    goto_edge(137);
    check("t4_lock_lost_e137", lock_lost, 0);
    check("t4_ready_e137",     ready,     1);
    goto_edge(138);
    check("t4_lock_lost_e138", lock_lost, 1);
    check("t4_ready_e138",     ready,     0);
    check("t4_rst_out_e138",   rst_out,   1);
    check("t4_pll_reset_e138", pll_reset, 1);
    check("t4_retries_e138",   retries,   0);
    goto_edge(139);
    check("t4_lock_lost_e139", lock_lost, 0);
    check("t4_pll_reset_e139", pll_reset, 1);
    goto_edge(141); check("t4_pll_reset_e141", pll_reset, 1);
    goto_edge(142); check("t4_pll_reset_e142", pll_reset, 0);

    // ---- Asynchronous reset mid-STABLE ----
    do_reset();
    goto_edge(10);
    lock = 1'b1;
    goto_edge(15);
    check("t6_pll_reset_pre", pll_reset, 0);
    #4;
    reset = 1'b1;
    #1;
    check("t6_async_pll_reset", pll_reset, 1);
    check("t6_async_rst_out",   rst_out,   1);
    check("t6_async_ready",     ready,     0);
    check("t6_async_fault",     fault,     0);
    check("t6_async_retries",   retries,   0);
    #2;
    reset = 1'b0;
    ecnt  = 0;
    goto_edge(3);  check("t6_pll_reset_e3", pll_reset, 1);
    goto_edge(4);  check("t6_pll_reset_e4", pll_reset, 0);
    goto_edge(14); check("t6_ready_e14",    ready,     0);
    goto_edge(15); check("t6_ready_e15",    ready,     1);

    check("invariant_violations", inv_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
